// File: rtl/gray_pkg.sv
// Shared types and helpers for the pipelined Gray-code codec.
package gray_pkg;

    // Storage width for the stage record; instances use the low DATA_WIDTH bits.
    localparam int unsigned GRAY_MAX_W = 64;
    localparam int unsigned GRAY_IDX_W = 6;

    typedef logic [GRAY_MAX_W-1:0] gray_word_t;

    // One pipeline slot: handshake valid, per-word mode, checker flag,
    // partially resolved word and the running prefix-XOR parity.
    typedef struct packed {
        logic       valid;
        logic       mode;
        logic       jump;
        gray_word_t data;
        logic       par;
    } gray_stage_t;

    function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
        return (a + b - 1) / b;
    endfunction

    function automatic gray_word_t gray_enc(input gray_word_t b);
        return b ^ (b >> 1);
    endfunction

    // True when the word has at most one bit set.
    function automatic logic gray_onehot_or_zero(input gray_word_t x);
        return (x & (x - gray_word_t'(1))) == '0;
    endfunction

endpackage

// File: rtl/gray_codec_stage.sv
// One register stage: resolves its slice of the Gray decode chain, or
// performs the full encode when it is the first stage.
module gray_codec_stage
    import gray_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 4,
    parameter int unsigned PIPE_STAGES = 2,
    parameter int unsigned STAGE       = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  gray_stage_t in_i,
    output gray_stage_t q_o
);

    localparam int unsigned CHUNK = ceil_div(DATA_WIDTH, PIPE_STAGES);

    gray_stage_t stg_d;
    gray_stage_t stg_q;
    logic        par;

    // Slice decode from the MSB side (k counts bits from the top), carrying parity onward.
    always_comb begin
        stg_d = in_i;
        par   = in_i.par;
        if (in_i.mode) begin
            if (STAGE == 0) begin
                stg_d.data = gray_enc(in_i.data);
            end
        end else begin
            for (int unsigned k = 0; k < DATA_WIDTH; k++) begin
                if ((k / CHUNK) == STAGE) begin
                    par = par ^ in_i.data[GRAY_IDX_W'(DATA_WIDTH - 1 - k)];
                    stg_d.data[GRAY_IDX_W'(DATA_WIDTH - 1 - k)] = par;
                end
            end
        end
        stg_d.par = par;
    end

    // Stage register: loads whenever it is empty or its word moves on.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stg_q <= '0;
        end else if (load_i) begin
            stg_q <= stg_d;
        end
    end

    assign q_o = stg_q;

endmodule

// File: rtl/gray_codec_pipe.sv
// Pipelined Gray encode/decode with valid/ready handshake and an optional
// adjacency checker on decoded words.
module gray_codec_pipe
    import gray_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 4,
    parameter int unsigned PIPE_STAGES = 2,
    parameter int unsigned CHECK_EN    = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic                  mode_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  jump_o
);

    localparam int unsigned LAST = PIPE_STAGES - 1;

    gray_stage_t              stg_in [PIPE_STAGES];
    gray_stage_t              stg_q  [PIPE_STAGES];
    logic [PIPE_STAGES-1:0]   stg_vld;
    logic [PIPE_STAGES-1:0]   stg_load;
    gray_word_t               data_ext;
    logic                     jump_in;
    logic                     in_xfer;

    assign data_ext = GRAY_MAX_W'(data_i);
    assign in_xfer  = valid_i & ready_o;

    if (CHECK_EN != 0) begin : g_chk
        gray_word_t prev_g_d;
        gray_word_t prev_g_q;
        logic       prev_vld_d;
        logic       prev_vld_q;

        // History tracks decode words only; encode words leave it untouched.
        always_comb begin
            prev_g_d   = prev_g_q;
            prev_vld_d = prev_vld_q;
            if (in_xfer && !mode_i) begin
                prev_g_d   = data_ext;
                prev_vld_d = 1'b1;
            end
        end

        // Checker history register.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                prev_g_q   <= '0;
                prev_vld_q <= 1'b0;
            end else begin
                prev_g_q   <= prev_g_d;
                prev_vld_q <= prev_vld_d;
            end
        end

        assign jump_in = !mode_i && prev_vld_q && !gray_onehot_or_zero(data_ext ^ prev_g_q);
    end else begin : g_nochk
        assign jump_in = 1'b0;
    end

    assign stg_in[0] = '{valid: valid_i, mode: mode_i, jump: jump_in, data: data_ext, par: 1'b0};

    for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
        // Stage s can load unless it and every stage after it are full and
        // the output is stalled; the closed form avoids a ripple through
        // the per-stage advance terms.
        localparam logic [PIPE_STAGES-1:0] BELOW = PIPE_STAGES'((64'd1 << s) - 64'd1);

        if (s > 0) begin : g_link
            assign stg_in[s] = stg_q[s-1];
        end

        assign stg_vld[s]  = stg_q[s].valid;
        assign stg_load[s] = ready_i | ~&(stg_vld | BELOW);

        gray_codec_stage #(
            .DATA_WIDTH (DATA_WIDTH),
            .PIPE_STAGES(PIPE_STAGES),
            .STAGE      (s)
        ) u_stage (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .load_i(stg_load[s]),
            .in_i  (stg_in[s]),
            .q_o   (stg_q[s])
        );
    end

    assign ready_o = stg_load[0];
    assign valid_o = stg_q[LAST].valid;
    assign data_o  = stg_q[LAST].data[DATA_WIDTH-1:0];
    assign jump_o  = stg_q[LAST].jump;

    logic unused_last;
    assign unused_last = ^{stg_q[LAST].par, stg_q[LAST].data >> DATA_WIDTH};

endmodule

// File: tb/tb_gray_codec_pipe.sv
module tb_gray_codec_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic       vA, mA, rdyA, voA, riA, joA;
    logic [3:0] dA, doA;
    logic        vB, mB, rdyB, voB, riB, joB;
    logic [15:0] dB, doB;
    logic       vC, mC, rdyC, voC, riC, joC;
    logic [3:0] dC, doC;

    gray_codec_pipe #(.DATA_WIDTH(4), .PIPE_STAGES(2), .CHECK_EN(1)) dut_a (
        .clk_i(clk), .rst_i(rst), .valid_i(vA), .ready_o(rdyA), .mode_i(mA), .data_i(dA),
        .valid_o(voA), .ready_i(riA), .data_o(doA), .jump_o(joA));

    gray_codec_pipe #(.DATA_WIDTH(16), .PIPE_STAGES(5), .CHECK_EN(1)) dut_b (
        .clk_i(clk), .rst_i(rst), .valid_i(vB), .ready_o(rdyB), .mode_i(mB), .data_i(dB),
        .valid_o(voB), .ready_i(riB), .data_o(doB), .jump_o(joB));

    gray_codec_pipe #(.DATA_WIDTH(4), .PIPE_STAGES(1), .CHECK_EN(0)) dut_c (
        .clk_i(clk), .rst_i(rst), .valid_i(vC), .ready_o(rdyC), .mode_i(mC), .data_i(dC),
        .valid_o(voC), .ready_i(riC), .data_o(doC), .jump_o(joC));

    typedef struct {
        logic [15:0] data;
        logic        jump;
        time         t;
        logic        lat;
    } exp_t;

    exp_t qA[$];
    exp_t qB[$];
    exp_t qC[$];

    int total = 0;
    int bad   = 0;

    logic [15:0] prev_g [3];
    logic        prev_v [3];
    logic        hold   [3];
    logic [15:0] hdata  [3];
    logic        hjump  [3];
    logic        doneB;

    function automatic logic [15:0] ref_dec(input logic [15:0] g, input int unsigned w);
        logic [15:0] b;
        logic acc;
        b = '0;
        acc = 1'b0;
        for (int unsigned k = 0; k < w; k++) begin
            acc = acc ^ g[w-1-k];
            b[w-1-k] = acc;
        end
        return b;
    endfunction

    function automatic logic [15:0] ref_enc(input logic [15:0] b, input int unsigned w);
        logic [15:0] y;
        y = '0;
        for (int unsigned k = 0; k < w; k++) begin
            if (k == w - 1) y[k] = b[k];
            else            y[k] = b[k] ^ b[k+1];
        end
        return y;
    endfunction

    function automatic logic rdy_of(input int u);
        case (u)
            0:       return rdyA;
            1:       return rdyB;
            default: return rdyC;
        endcase
    endfunction

    function automatic int qsize(input int u);
        case (u)
            0:       return qA.size();
            1:       return qB.size();
            default: return qC.size();
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one word on DUT u, wait (bounded) for acceptance, push the expectation.
    task automatic send(input int u, input logic m, input logic [15:0] d);
        int          n;
        int unsigned w;
        exp_t        e;
        logic [15:0] g;
        case (u)
            0:       begin vA = 1'b1; mA = m; dA = d[3:0]; end
            1:       begin vB = 1'b1; mB = m; dB = d;      end
            default: begin vC = 1'b1; mC = m; dC = d[3:0]; end
        endcase
        w = (u == 1) ? 16 : 4;
        g = (u == 1) ? d : {12'b0, d[3:0]};
        n = 0;
        @(negedge clk);
        while (!rdy_of(u) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("accept_%0d", u), 32'(rdy_of(u)), 32'd1);
        if (rdy_of(u)) begin
            @(posedge clk);
            e.data = m ? ref_enc(g, w) : ref_dec(g, w);
            e.jump = (u != 2) && !m && prev_v[u] && ($countones(g ^ prev_g[u]) > 1);
            if (!m) begin
                prev_g[u] = g;
                prev_v[u] = 1'b1;
            end
            e.t   = $time;
            e.lat = (u != 1);
            case (u)
                0:       qA.push_back(e);
                1:       qB.push_back(e);
                default: qC.push_back(e);
            endcase
            #1;
        end
    endtask

    task automatic mon(input int u, input logic vo, input logic ri, input logic jo,
                       input logic [15:0] dout, input logic rdy);
        exp_t        e;
        int unsigned s;
        if (rst) begin
            hold[u] = 1'b0;
            return;
        end
        s = (u == 0) ? 2 : (u == 1) ? 5 : 1;
        if (hold[u]) begin
            chk($sformatf("stall_valid_%0d", u), 32'(vo), 32'd1);
            chk($sformatf("stall_data_%0d", u), 32'(dout), 32'(hdata[u]));
            chk($sformatf("stall_jump_%0d", u), 32'(jo), 32'(hjump[u]));
        end
        if (u == 1) begin
            chk("b_ready", 32'(rdy), 32'(!(qB.size() == 5 && !ri)));
        end
        if (vo && ri) begin
            if (qsize(u) == 0) begin
                chk($sformatf("spurious_valid_%0d", u), 32'(vo), 32'd0);
            end else begin
                case (u)
                    0:       e = qA.pop_front();
                    1:       e = qB.pop_front();
                    default: e = qC.pop_front();
                endcase
                chk($sformatf("data_%0d", u), 32'(dout), 32'(e.data));
                chk($sformatf("jump_%0d", u), 32'(jo), 32'(e.jump));
                if (e.lat) begin
                    chk($sformatf("latency_%0d", u), 32'($time - e.t), (s - 1) * 10 + 5);
                end
            end
        end
        hold[u]  = vo && !ri;
        hdata[u] = dout;
        hjump[u] = jo;
    endtask

    always @(negedge clk) begin
        mon(0, voA, riA, joA, {12'b0, doA}, rdyA);
        mon(1, voB, riB, joB, doB, rdyB);
        mon(2, voC, riC, joC, {12'b0, doC}, rdyC);
    end

    initial begin
        int n;
        rst = 1'b1;
        vA = 1'b0; mA = 1'b0; dA = '0; riA = 1'b1;
        vB = 1'b0; mB = 1'b0; dB = '0; riB = 1'b1;
        vC = 1'b0; mC = 1'b0; dC = '0; riC = 1'b1;
        doneB = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            prev_g[i] = '0;
            prev_v[i] = 1'b0;
            hold[i]   = 1'b0;
            hdata[i]  = '0;
            hjump[i]  = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_valid_a", 32'(voA), 32'd0);
        chk("rst_data_a", 32'(doA), 32'd0);
        chk("rst_jump_a", 32'(joA), 32'd0);
        chk("rst_ready_a", 32'(rdyA), 32'd1);
        chk("rst_valid_b", 32'(voB), 32'd0);
        chk("rst_ready_b", 32'(rdyB), 32'd1);
        @(posedge clk);
        #1;

        // Gray count decoded back-to-back.
        for (int unsigned i = 0; i < 16; i++) begin
            send(0, 1'b0, 16'(i ^ (i >> 1)));
        end
        // Binary count encoded back-to-back.
        for (int unsigned i = 0; i < 16; i++) begin
            send(0, 1'b1, 16'(i));
        end
        // Adjacency checker: two-bit jump then a single-bit step.
        send(0, 1'b0, 16'b0011);
        send(0, 1'b0, 16'b0101);
        send(0, 1'b0, 16'b0100);
        vA = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Wide pipe, alternating modes, random downstream stalls.
        fork
            begin
                for (int unsigned k = 0; k < 40; k++) begin
                    send(1, k[0], 16'($urandom));
                end
                vB = 1'b0;
                doneB = 1'b1;
            end
            begin
                while (!doneB) begin
                    @(posedge clk);
                    #1 riB = 1'($urandom_range(0, 1));
                end
                riB = 1'b1;
            end
        join
        n = 0;
        while (qB.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;

        // Asynchronous reset with three words in flight.
        riA = 1'b0;
        send(0, 1'b0, 16'b0001);
        send(0, 1'b0, 16'b0011);
        vA = 1'b1; mA = 1'b0; dA = 4'b0111;
        @(negedge clk);
        chk("a_full_ready", 32'(rdyA), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(voA), 32'd0);
        chk("arst_data", 32'(doA), 32'd0);
        chk("arst_ready", 32'(rdyA), 32'd1);
        chk("arst_jump", 32'(joA), 32'd0);
        vA = 1'b0;
        riA = 1'b1;
        qA.delete();
        prev_v[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        send(0, 1'b0, 16'b1111);
        vA = 1'b0;

        // Single-stage, checker disabled.
        send(2, 1'b0, 16'b0000);
        send(2, 1'b0, 16'b1111);
        vC = 1'b0;

        n = 0;
        while ((qA.size() + qB.size() + qC.size()) != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(qA.size() + qB.size() + qC.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
